// File: rtl/wb_retire_v.sv
// wb_retire_v: write-back retire queue for one vector lane.
// Optional same-cycle ALU bypass when empty: define WB_BYPASS_EN.
module wb_retire_v #(
  parameter int DEPTH       = 4,
  parameter int WIDTH_DEPTH = $clog2(DEPTH),
  parameter int IDX_W       = 5,
  parameter int DAT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Stall,
  input  logic             I_Valid_A,
  input  logic [IDX_W-1:0] I_Index_A,
  input  logic [DAT_W-1:0] I_Data_A,
  input  logic             I_Valid_B,
  input  logic [IDX_W-1:0] I_Index_B,
  input  logic [DAT_W-1:0] I_Data_B,
  output logic             O_WB_Valid,
  output logic [IDX_W-1:0] O_WB_Index,
  output logic [DAT_W-1:0] O_WB_Data,
  output logic             O_Full,
  output logic             O_Empty,
  output logic             O_Overflow
);

  localparam int CW = WIDTH_DEPTH + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] L_ONE   = CW'(1);
  localparam logic [CW-1:0] L_TWO   = CW'(2);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DAT_W-1:0] dat;
  } entry_t;

  entry_t                 r_mem [DEPTH];
  logic [WIDTH_DEPTH-1:0] r_rptr;
  logic [WIDTH_DEPTH-1:0] r_wptr;
  logic [CW-1:0]          r_count;
  logic                   r_ovf;

  logic                   w_deq;
  logic                   w_bypass;
  logic                   w_want_a;
  logic                   w_wr_a;
  logic                   w_wr_b;
  logic                   w_drop;
  logic [CW-1:0]          w_free;
  logic [CW-1:0]          w_need_b;
  logic [CW-1:0]          w_enq_n;
  logic [WIDTH_DEPTH-1:0] w_b_ptr;

`ifdef WB_BYPASS_EN
  assign w_bypass = (r_count == '0) && !I_Stall && I_Valid_A;
`else
  assign w_bypass = 1'b0;
`endif

  // Free space counts the slot being retired this cycle, so a full
  // queue that retires can still accept one result.
  assign w_deq    = (r_count != '0) && !I_Stall;
  assign w_free   = L_DEPTH - r_count + {{WIDTH_DEPTH{1'b0}}, w_deq};
  assign w_want_a = I_Valid_A && !w_bypass;
  assign w_wr_a   = w_want_a && (w_free >= L_ONE);
  assign w_need_b = w_wr_a ? L_TWO : L_ONE;
  assign w_wr_b   = I_Valid_B && (w_free >= w_need_b);
  assign w_drop   = (w_want_a && !w_wr_a) || (I_Valid_B && !w_wr_b);
  assign w_enq_n  = {{WIDTH_DEPTH{1'b0}}, w_wr_a}
                  + {{WIDTH_DEPTH{1'b0}}, w_wr_b};
  assign w_b_ptr  = r_wptr + {{(WIDTH_DEPTH-1){1'b0}}, w_wr_a};

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_rptr  <= r_rptr + {{(WIDTH_DEPTH-1){1'b0}}, w_deq};
      r_wptr  <= r_wptr + w_enq_n[WIDTH_DEPTH-1:0];
      r_count <= r_count + w_enq_n - {{WIDTH_DEPTH{1'b0}}, w_deq};
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Entry storage; A lands at wptr, B directly behind it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_wr_a) r_mem[r_wptr]  <= '{idx: I_Index_A, dat: I_Data_A};
      if (w_wr_b) r_mem[w_b_ptr] <= '{idx: I_Index_B, dat: I_Data_B};
    end
  end

  // Write-back bus: bypassed A, else the head entry, else zero.
  always_comb begin
    O_WB_Valid = 1'b0;
    O_WB_Index = '0;
    O_WB_Data  = '0;
    if (w_bypass) begin
      O_WB_Valid = 1'b1;
      O_WB_Index = I_Index_A;
      O_WB_Data  = I_Data_A;
    end else if (w_deq) begin
      O_WB_Valid = 1'b1;
      O_WB_Index = r_mem[r_rptr].idx;
      O_WB_Data  = r_mem[r_rptr].dat;
    end
  end

  assign O_Full     = (L_DEPTH - r_count) < L_TWO;
  assign O_Empty    = (r_count == '0);
  assign O_Overflow = r_ovf;

endmodule
